// File: rtl/dms_encoder.sv
// dms_encoder: transmit-side stage feeding the SAM2 decryption decoder.
// Serialises the configuration frame (n, d, capsN) with mode=1, then pulse-width
// encodes the message bits with mode=0 (symbol starts with a rising edge, the
// majority level carries the bit), then a two-cycle flush and a done pulse.
// Optional feature: define DMS_ENC_PARITY_EN to append an even-parity symbol
// after the last message bit.
module dms_encoder #(
    parameter int MAX_N     = 5,
    parameter int SYM_LEN   = 8,
    parameter int ONE_HIGH  = 6,
    parameter int ZERO_HIGH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  cfg_n,
    input  logic [31:0] cfg_d,
    input  logic [31:0] cfg_caps,
    input  logic        bit_valid,
    input  logic        bit_data,
    input  logic        bit_last,
    output logic        bit_ready,
    output logic        str,
    output logic        mode,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG_N,
        S_CFG_D,
        S_CFG_CAPS,
        S_GAP,
        S_WAIT,
        S_SYM,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [5:0] SYM_LAST = 6'(SYM_LEN - 1);
    localparam logic [5:0] ONE_HI   = 6'(ONE_HIGH);
    localparam logic [5:0] ZERO_HI  = 6'(ZERO_HIGH);
    localparam logic [3:0] N_MAX    = 4'(MAX_N);

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [3:0]  n_q, n_d;
    logic [31:0] key_q, key_d;
    logic [31:0] caps_q, caps_d;
    logic        bit_q, bit_d;
    logic        last_q, last_d;
`ifdef DMS_ENC_PARITY_EN
    logic        par_q, par_d;
    logic        is_par_q, is_par_d;
`endif

    logic        str_q, str_d;
    logic        mode_q, mode_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        ready_q, ready_d;

    logic        xfer;
    logic [5:0]  cfg_last;
    logic [5:0]  out_last;
    logic [4:0]  out_idx;
    logic [1:0]  n_idx;
    logic [5:0]  hi_len;

    // Next-state logic: sequencing through config, data symbols, flush and done
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        key_d    = key_q;
        caps_d   = caps_q;
        bit_d    = bit_q;
        last_d   = last_q;
`ifdef DMS_ENC_PARITY_EN
        par_d    = par_q;
        is_par_d = is_par_q;
`endif
        xfer     = bit_valid & ready_q;
        cfg_last = (6'd1 << n_q) - 6'd1;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_CFG_N;
                    cnt_d    = '0;
                    n_d      = (cfg_n > N_MAX) ? N_MAX : cfg_n;
                    key_d    = cfg_d;
                    caps_d   = cfg_caps;
`ifdef DMS_ENC_PARITY_EN
                    par_d    = 1'b0;
                    is_par_d = 1'b0;
`endif
                end
            end
            S_CFG_N: begin
                if (cnt_q == 6'd3) begin
                    state_d = S_CFG_D;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_CFG_D: begin
                if (cnt_q == cfg_last) begin
                    state_d = S_CFG_CAPS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_CFG_CAPS: begin
                if (cnt_q == cfg_last) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_GAP: begin
                state_d = S_WAIT;
                cnt_d   = '0;
            end
            S_WAIT: begin
                if (xfer) begin
                    state_d = S_SYM;
                    cnt_d   = '0;
                    bit_d   = bit_data;
                    last_d  = bit_last;
`ifdef DMS_ENC_PARITY_EN
                    par_d   = par_q ^ bit_data;
`endif
                end
            end
            S_SYM: begin
                if (cnt_q == SYM_LAST) begin
                    cnt_d = '0;
                    if (xfer) begin
                        state_d = S_SYM;
                        bit_d   = bit_data;
                        last_d  = bit_last;
`ifdef DMS_ENC_PARITY_EN
                        par_d   = par_q ^ bit_data;
`endif
                    end else if (last_q) begin
`ifdef DMS_ENC_PARITY_EN
                        // last_q stays set through the parity symbol, so bit_ready stays low
                        if (!is_par_q) begin
                            state_d  = S_SYM;
                            bit_d    = par_q;
                            is_par_d = 1'b1;
                        end else begin
                            state_d = S_FLUSH;
                        end
`else
                        state_d = S_FLUSH;
`endif
                    end else begin
                        state_d = S_WAIT;
                    end
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_FLUSH: begin
                if (cnt_q == 6'd1) begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        str_d    = 1'b0;
        mode_d   = 1'b0;
        busy_d   = (state_d != S_IDLE);
        done_d   = 1'b0;
        ready_d  = 1'b0;
        out_last = (6'd1 << n_d) - 6'd1;
        out_idx  = 5'(out_last - cnt_d);
        n_idx    = 2'd3 - cnt_d[1:0];
        hi_len   = bit_d ? ONE_HI : ZERO_HI;

        case (state_d)
            S_CFG_N: begin
                mode_d = 1'b1;
                str_d  = n_d[n_idx];
            end
            S_CFG_D: begin
                mode_d = 1'b1;
                str_d  = key_d[out_idx];
            end
            S_CFG_CAPS: begin
                mode_d = 1'b1;
                str_d  = caps_d[out_idx];
            end
            S_WAIT: begin
                ready_d = 1'b1;
            end
            S_SYM: begin
                str_d   = (cnt_d < hi_len);
                ready_d = (cnt_d == SYM_LAST) && !last_d;
            end
            S_FLUSH: begin
                str_d = (cnt_d == 6'd0);
            end
            S_DONE: begin
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State, latched frame data and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            n_q      <= '0;
            key_q    <= '0;
            caps_q   <= '0;
            bit_q    <= 1'b0;
            last_q   <= 1'b0;
`ifdef DMS_ENC_PARITY_EN
            par_q    <= 1'b0;
            is_par_q <= 1'b0;
`endif
            str_q    <= 1'b0;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            n_q      <= n_d;
            key_q    <= key_d;
            caps_q   <= caps_d;
            bit_q    <= bit_d;
            last_q   <= last_d;
`ifdef DMS_ENC_PARITY_EN
            par_q    <= par_d;
            is_par_q <= is_par_d;
`endif
            str_q    <= str_d;
            mode_q   <= mode_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ready_q  <= ready_d;
        end
    end

    assign str       = str_q;
    assign mode      = mode_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign bit_ready = ready_q;

endmodule

// File: tb/tb_dms_encoder.sv
// Testbench for dms_encoder: builds the expected per-cycle waveform of each frame
// from the frame rules (config bits, gap, waits, symbols, flush, done) and drives
// the message bits on the planned cycles, with random noise on ignored inputs.
module tb_dms_encoder;

    localparam int SYM_LEN   = 8;
    localparam int ONE_HIGH  = 6;
    localparam int ZERO_HIGH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cfg_n;
    logic [31:0] cfg_d;
    logic [31:0] cfg_caps;
    logic        bit_valid;
    logic        bit_data;
    logic        bit_last;
    logic        bit_ready;
    logic        str;
    logic        mode;
    logic        busy;
    logic        done;

    dms_encoder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .cfg_n     (cfg_n),
        .cfg_d     (cfg_d),
        .cfg_caps  (cfg_caps),
        .bit_valid (bit_valid),
        .bit_data  (bit_data),
        .bit_last  (bit_last),
        .bit_ready (bit_ready),
        .str       (str),
        .mode      (mode),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] o;    // {str, mode, bit_ready, busy, done}
        logic       v;
        logic       dat;
        logic       lst;
    } ent_t;

    ent_t exp_q[$];
    int   bits_q[$];
    int   gaps_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   frame_no = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {27'd0, str, mode, bit_ready, busy, done};
    endfunction

    // Non-ready cycles get random bit_* noise, which the encoder must ignore
    task automatic push(input logic s, input logic m, input logic r, input logic bz,
                        input logic dn, input logic v, input logic dat, input logic lst);
        ent_t e;
        e.o = {s, m, r, bz, dn};
        if (r) begin
            e.v = v; e.dat = dat; e.lst = lst;
        end else begin
            e.v   = 1'($urandom_range(0, 1));
            e.dat = 1'($urandom_range(0, 1));
            e.lst = 1'($urandom_range(0, 1));
        end
        exp_q.push_back(e);
    endtask

    // Expected waveform for one frame; gaps_q[k] = idle ready cycles before bit k
    task automatic build(input logic [3:0] n_raw, input logic [31:0] d, input logic [31:0] caps);
        int nn, len, nb, par, b, w_cnt;
        logic [3:0] nv;
        logic lst, rdy, v;
        nn  = (n_raw > 4'd5) ? 5 : int'(n_raw);
        nv  = 4'(nn);
        len = 1 << nn;
        nb  = bits_q.size();
        exp_q.delete();
        for (int i = 0; i < 4; i++)   push(nv[3 - i], 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < len; i++) push(d[len - 1 - i], 1, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < len; i++) push(caps[len - 1 - i], 1, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 0, 0, 0);
        par = 0;
        for (int k = 0; k < nb; k++) begin
            b   = bits_q[k];
            lst = (k == nb - 1);
            if (k == 0 || gaps_q[k] != 0) begin
                w_cnt = (k == 0) ? gaps_q[0] + 1 : gaps_q[k];
                for (int w = 0; w < w_cnt; w++)
                    push(0, 0, 1, 1, 0, (w == w_cnt - 1), 1'(b), lst);
            end
            par ^= b;
            for (int j = 0; j < SYM_LEN; j++) begin
                rdy = (j == SYM_LEN - 1) && !lst;
                v   = rdy && (gaps_q[k + 1] == 0);
                push(j < (b != 0 ? ONE_HIGH : ZERO_HIGH), 0, rdy, 1, 0, v,
                     rdy ? 1'(bits_q[k + 1]) : 1'b0, (k + 1 == nb - 1));
            end
        end
`ifdef DMS_ENC_PARITY_EN
        for (int j = 0; j < SYM_LEN; j++)
            push(j < (par != 0 ? ONE_HIGH : ZERO_HIGH), 0, 0, 1, 0, 0, 0, 0);
`endif
        push(1, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 1, 0, 0, 0, 0);
        push(0, 0, 0, 1, 1, 0, 0, 0);
    endtask

    task automatic run_frame(input logic [3:0] n, input logic [31:0] d, input logic [31:0] caps,
                             input int abort_at);
        build(n, d, caps);
        frame_no++;
        @(posedge clk); #1;
        check_eq($sformatf("f%0d_idle", frame_no), outs(), 0);
        start = 1'b1; cfg_n = n; cfg_d = d; cfg_caps = caps;
        bit_valid = 1'b0;
        for (int i = 0; i < exp_q.size(); i++) begin
            @(posedge clk); #1;
            check_eq($sformatf("f%0d_c%0d", frame_no, i), outs(), 32'(exp_q[i].o));
            if (i == abort_at) begin
                reset = 1'b1;
                start = 1'($urandom_range(0, 1));
                bit_valid = 1'b1;
                @(posedge clk); #1;
                check_eq($sformatf("f%0d_rst", frame_no), outs(), 0);
                reset = 1'b0; start = 1'b0; bit_valid = 1'b0;
                return;
            end
            start     = ($urandom_range(0, 3) == 0);
            cfg_n     = 4'($urandom);
            cfg_d     = $urandom;
            cfg_caps  = $urandom;
            bit_valid = exp_q[i].v;
            bit_data  = exp_q[i].dat;
            bit_last  = exp_q[i].lst;
        end
        start = 1'b0; bit_valid = 1'b0;
    endtask

    task automatic set_msg2(input int b0, input int b1, input int g0, input int g1);
        bits_q = '{b0, b1};
        gaps_q = '{g0, g1};
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_n = '0; cfg_d = '0; cfg_caps = '0;
        bit_valid = 1'b0; bit_data = 1'b0; bit_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset", outs(), 0);
        reset = 1'b0;

        // config shape + back-to-back symbols 1, 0(last)
        set_msg2(1, 0, 0, 0);
        run_frame(4'd2, 32'hA, 32'h1, -1);

        // underrun between bits
        bits_q = '{1, 0, 1};
        gaps_q = '{0, 5, 0};
        run_frame(4'd1, 32'h2, 32'h1, -1);

        // clamp of n
        bits_q = '{0};
        gaps_q = '{2};
        run_frame(4'hF, $urandom, $urandom, -1);

        // reset mid CFG_D, then replay
        set_msg2(1, 1, 1, 0);
        run_frame(4'd3, 32'hA5, 32'h3C, 4 + 3);
        run_frame(4'd3, 32'hA5, 32'h3C, -1);

        // parity cases (even-parity symbol when enabled)
        bits_q = '{1, 1, 0};
        gaps_q = '{0, 0, 0};
        run_frame(4'd0, 32'h1, 32'h0, -1);
        set_msg2(1, 0, 0, 0);
        run_frame(4'd1, 32'h3, 32'h2, -1);

        for (int f = 0; f < 20; f++) begin
            int nb;
            nb = $urandom_range(1, 6);
            bits_q.delete();
            gaps_q.delete();
            for (int k = 0; k < nb; k++) begin
                bits_q.push_back($urandom_range(0, 1));
                gaps_q.push_back(($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 3));
            end
            run_frame(4'($urandom), $urandom, $urandom, -1);
        end

        @(posedge clk); #1;
        check_eq("final_idle", outs(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dms_encoder.md
Name: dms_encoder

Overview:
- Transmit-side stage directly upstream of the SAM2 decryption decoder.
- Serialises a configuration frame (n, d, capsN) on `str` with `mode`=1, then pulse-width encodes a message bit stream with `mode`=0.
- Each message symbol starts with a 0→1 edge; the majority level within the symbol carries the bit.
- Drives the decoder's `str`/`mode` inputs one-to-one, with both running on the same `clk`.

Parameters:
- MAX_N, 5: largest accepted cfg_n; d/capsN payload is 2^cfg_n bits, at most 32.
- SYM_LEN, 8: cycles per message symbol.
- ONE_HIGH, 6: high cycles at the start of a '1' symbol.
- ZERO_HIGH, 2: high cycles at the start of a '0' symbol.
- Legal ranges: 1 <= ZERO_HIGH < SYM_LEN/2 < ONE_HIGH <= SYM_LEN-1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches cfg_* and begins a frame; honoured only in IDLE.
- cfg_n  in  4  key size exponent n.
- cfg_d  in  32  key d; bits [2^n-1:0] used.
- cfg_caps  in  32  capsN mask; bits [2^n-1:0] used.
- bit_valid  in  1  message bit offered.
- bit_data  in  1  message bit value.
- bit_last  in  1  qualifies the final bit of the message.
- bit_ready  out  1  encoder accepts bit this cycle (transfer = valid & ready).
- str  out  1  serial line to decoder.
- mode  out  1  1 = configuration phase, 0 = data phase.
- busy  out  1  high from cycle after accepted start until done.
- done  out  1  one-cycle pulse at end of frame.

Behaviour:
- Reset: state IDLE, counters 0. Outputs str=0, mode=0, busy=0, done=0, bit_ready=0. Reset wins over start and over any transfer in the same cycle. Reset mid-frame aborts with no flush.
- All outputs are registered. start sampled in cycle t gives mode=1, str=cfg_n[3] in cycle t+1.
- cfg_n > MAX_N is clamped to MAX_N at latch. Latched cfg values are held until done; input changes during the frame are ignored.
- State CFG_N: 4 cycles, str = n[3],n[2],n[1],n[0]; mode=1.
- State CFG_D: 2^n cycles, str = d[2^n-1] down to d[0]; mode=1.
- State CFG_CAPS: 2^n cycles, str = caps[2^n-1] down to caps[0]; mode=1.
- State GAP: 1 cycle, mode=0, str=0. Guarantees the decoder sees prevBit=0. Goes to WAIT.
- State WAIT: mode=0, str=0, bit_ready=1. On transfer, latch bit and last flag, go to SYM.
- State SYM: SYM_LEN cycles with symbol counter 0..SYM_LEN-1.
  - str=1 while counter < (bit ? ONE_HIGH : ZERO_HIGH), else 0.
  - bit_ready=1 only on counter==SYM_LEN-1 and only if the current bit is not last. A transfer there starts the next SYM immediately (back-to-back, zero idle cycles).
  - If no transfer on the final cycle, go to WAIT.
  - If the current bit is last, go to FLUSH after the final cycle.
- State FLUSH: 2 cycles, str=1 then str=0. The rising edge commits the last symbol in the decoder. mode=0.
- State DONE: 1 cycle, done=1, busy=0 next cycle. Returns to IDLE. mode=0, str=0.
- Frame length: 5 + 2·2^n config/gap cycles; SYM_LEN per bit; +2 flush.
- bit_valid in IDLE or config states is ignored (bit_ready=0). start outside IDLE is ignored.
- Empty message is not supported: the first accepted bit may carry bit_last=1, giving a 1-bit message.

Optional Feature:
- Macro: DMS_ENC_PARITY_EN.
- With the macro defined:
  - Encoder keeps an XOR of all accepted bits in the frame.
  - After the last bit's SYM, it emits one extra SYM carrying the even-parity bit, then FLUSH.
  - bit_ready stays 0 during the parity symbol.
- Without the macro: no parity logic; last SYM goes straight to FLUSH.

Test Plan:
1. Config shape: start with cfg_n=2, cfg_d=32'hA, cfg_caps=32'h1. Required on str with mode=1 for 12 cycles: 0,0,1,0, 1,0,1,0, 0,0,0,1. Then 1 cycle of mode=0, str=0.
2. Symbol shape: after test 1, feed bit_data=1, then 0 (last) back-to-back. Required on str: 11111100 then 11000000, then flush 1,0, then done pulse. bit_ready high exactly on the last cycle of symbol 1.
3. Underrun: hold bit_valid=0 for 5 cycles between bits. Required: str=0, mode=0, bit_ready=1 throughout; next symbol starts the cycle after the transfer.
4. Clamp: cfg_n=4'hF. Required: n sent as 0,1,0,1 and 32 d bits, 32 caps bits.
5. Reset mid-CFG_D: assert reset. Required: next cycle all outputs 0, state IDLE; a new start replays the frame from n[3].
6. With DMS_ENC_PARITY_EN: bits 1,1,0(last). Required: an extra '0' symbol (11000000) before flush. With bits 1,0(last) the extra symbol is '1' (11111100).
